// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: operation codes, FSM states
// and the kinds of single-bit shift step.
package alu_pkg;

    localparam logic [3:0] ADD = 4'd0;
    localparam logic [3:0] SUB = 4'd1;
    localparam logic [3:0] AND = 4'd2;
    localparam logic [3:0] OR  = 4'd3;
    localparam logic [3:0] XOR = 4'd4;
    localparam logic [3:0] NOT = 4'd5;
    localparam logic [3:0] SLA = 4'd6;
    localparam logic [3:0] SRA = 4'd7;
    localparam logic [3:0] SRL = 4'd8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SK_SLA = 2'd0,
        SK_SRA = 2'd1,
        SK_SRL = 2'd2
    } shift_kind_t;

    // True for the three iterative shift operations.
    function automatic logic is_shift(input logic [3:0] f);
        return (f == SLA) || (f == SRA) || (f == SRL);
    endfunction

endpackage

// File: rtl/alu_seq_core_if.sv
// Operand/result bus of the sequential ALU.
//
// Handshake: each side is a valid/ready pair. A transfer happens on a rising
// clock edge where valid && ready. The source holds valid and its payload
// stable until that edge; ready may depend combinationally on state but never
// on the same-cycle valid of the opposite direction.
interface alu_seq_core_if #(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic [3:0]       funct;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;
    logic             err;

    modport master (
        output in_valid, a, b, shamt, funct, out_ready,
        input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, err
    );

    modport slave (
        input  in_valid, a, b, shamt, funct, out_ready,
        output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, err
    );

endinterface

// File: rtl/alu_shift_step.sv
// Combinational single-bit shift used once per SHIFT cycle. Reports the bit
// that falls off and whether a left shift flipped the sign bit.
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data_i,
    input  shift_kind_t      kind_i,
    output logic [WIDTH-1:0] data_o,
    output logic             bit_out_o,
    output logic             sign_chg_o
);

    // One-bit shift selected by kind; right shifts never report a sign change.
    always_comb begin
        data_o     = data_i;
        bit_out_o  = 1'b0;
        sign_chg_o = 1'b0;
        case (kind_i)
            SK_SLA: begin
                data_o     = {data_i[WIDTH-2:0], 1'b0};
                bit_out_o  = data_i[WIDTH-1];
                sign_chg_o = data_i[WIDTH-1] ^ data_i[WIDTH-2];
            end
            SK_SRA: begin
                data_o    = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
                bit_out_o = data_i[0];
            end
            SK_SRL: begin
                data_o    = {1'b0, data_i[WIDTH-1:1]};
                bit_out_o = data_i[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq_core.sv
// Registered ALU with valid/ready handshakes. Single-cycle ops produce a
// result one cycle after accept; shifts iterate one bit per cycle.
module alu_seq_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_seq_core_if.slave  bus,
    output state_t         state_o
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d, err_q, err_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    shift_kind_t      kind_q, kind_d;

    logic             accept, consume, start_shift;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] op_res;
    logic             op_c, op_v, op_err;
    shift_kind_t      op_kind;
    logic [WIDTH-1:0] step_data;
    logic             step_bit, step_sgn;

    assign bus.in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign consume      = out_valid_q && bus.out_ready;
    assign start_shift  = is_shift(bus.funct) && (bus.shamt != '0);

    assign sum  = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff = {1'b0, bus.a} - {1'b0, bus.b};

    // The working register doubles as the shift accumulator.
    alu_shift_step #(.WIDTH(WIDTH)) u_step (
        .data_i     (result_q),
        .kind_i     (kind_q),
        .data_o     (step_data),
        .bit_out_o  (step_bit),
        .sign_chg_o (step_sgn)
    );

    // Decode the presented operation into its one-cycle result and flags.
    always_comb begin
        op_res  = '0;
        op_c    = 1'b0;
        op_v    = 1'b0;
        op_err  = 1'b0;
        op_kind = SK_SLA;
        case (bus.funct)
            ADD: begin
                op_res = sum[WIDTH-1:0];
                op_c   = sum[WIDTH];
                op_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            SUB: begin
                op_res = diff[WIDTH-1:0];
                op_c   = !diff[WIDTH];
                op_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            AND: op_res = bus.a & bus.b;
            OR:  op_res = bus.a | bus.b;
            XOR: op_res = bus.a ^ bus.b;
            NOT: op_res = ~bus.a;
            SLA: op_res = bus.a;
            SRA: begin
                op_res  = bus.a;
                op_kind = SK_SRA;
            end
            SRL: begin
                op_res  = bus.a;
                op_kind = SK_SRL;
            end
            default: op_err = 1'b1;
        endcase
    end

    // Next state: only a shift with a non-zero amount visits SHIFT/DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && start_shift) state_d = SHIFT;
            SHIFT:   if (cnt_q == SHW'(1)) state_d = DONE;
            DONE:    if (consume) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: load on accept, step while shifting, drop valid on consume.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        z_d         = z_q;
        n_d         = n_q;
        c_d         = c_q;
        v_d         = v_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        kind_d      = kind_q;
        if (consume) out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    result_d    = op_res;
                    c_d         = op_c;
                    v_d         = op_v;
                    err_d       = op_err;
                    z_d         = (op_res == '0);
                    n_d         = op_res[WIDTH-1];
                    kind_d      = op_kind;
                    cnt_d       = bus.shamt;
                    out_valid_d = !start_shift;
                end
            end
            SHIFT: begin
                result_d = step_data;
                c_d      = step_bit;
                v_d      = v_q | step_sgn;
                cnt_d    = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    out_valid_d = 1'b1;
                    z_d         = (step_data == '0);
                    n_d         = step_data[WIDTH-1];
                end
            end
            default: ;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Datapath registers; reset aborts any shift in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            kind_q      <= SK_SLA;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            z_q         <= z_d;
            n_q         <= n_d;
            c_q         <= c_d;
            v_q         <= v_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            kind_q      <= kind_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flag_z    = z_q;
    assign bus.flag_n    = n_q;
    assign bus.flag_c    = c_q;
    assign bus.flag_v    = v_q;
    assign bus.err       = err_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Bench for alu_seq_core at WIDTH=8: directed cases, illegal codes,
// backpressure, back-to-back throughput, reset during a shift, random ops.
module tb_alu_seq_core;
    import alu_pkg::*;

    localparam int W  = 8;
    localparam int SW = 3;

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         n;
        logic         c;
        logic         v;
        logic         err;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_t state_o;
    int     total = 0;
    int     bad = 0;
    logic [W+4:0] exp_q[$];

    alu_seq_core_if #(.WIDTH(W)) bus ();

    alu_seq_core #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (state_o)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: plain integer arithmetic on the operation definitions.
    function automatic exp_t model(input logic [3:0] f, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [SW-1:0] sh);
        exp_t e;
        int   ua, ub, sa, sb, r, s;
        e  = '0;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        s  = sh;
        case (f)
            4'd0: begin
                r = ua + ub;  e.res = r[W-1:0];  e.c = (r > 255);
                e.v = (sa + sb > 127) || (sa + sb < -128);
            end
            4'd1: begin
                r = ua - ub;  e.res = r[W-1:0];  e.c = (ua >= ub);
                e.v = (sa - sb > 127) || (sa - sb < -128);
            end
            4'd2: e.res = a & b;
            4'd3: e.res = a | b;
            4'd4: e.res = a ^ b;
            4'd5: e.res = ~a;
            4'd6: begin
                r = sa * (1 << s);  e.res = r[W-1:0];
                e.v = (r > 127) || (r < -128);
                if (s != 0) e.c = a[W-s];
            end
            4'd7: begin
                r = sa >>> s;  e.res = r[W-1:0];
                if (s != 0) e.c = a[s-1];
            end
            4'd8: begin
                r = ua >> s;  e.res = r[W-1:0];
                if (s != 0) e.c = a[s-1];
            end
            default: e.err = 1'b1;
        endcase
        e.z = (e.res == '0);
        e.n = e.res[W-1];
        return e;
    endfunction

    function automatic logic [W+4:0] obs();
        return {bus.result, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.err};
    endfunction

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.shamt     = '0;
        bus.funct     = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Issue one op with out_ready high; check latency, busy in_ready, result and consume.
    task automatic run_op(input logic [3:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [SW-1:0] sh);
        logic [W+4:0] e;
        int lat, exp_lat, guard;
        exp_q.push_back(model(f, a, b, sh));
        exp_lat = ((f >= 4'd6) && (f <= 4'd8) && (sh != 0)) ? int'(sh) + 1 : 1;
        bus.in_valid = 1'b1;
        bus.funct = f;  bus.a = a;  bus.b = b;  bus.shamt = sh;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_timeout f=%0d got in_ready=%b exp=1", f, bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a = W'($urandom);  bus.b = W'($urandom);  bus.shamt = SW'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            total++;
            if (bus.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL busy_in_ready f=%0d got=%b exp=0", f, bus.in_ready);
            end
            @(posedge clk); #1; lat++;
        end
        e = exp_q.pop_front();
        total++;
        if (lat !== exp_lat) begin
            bad++;
            $display("FAIL latency f=%0d a=%h sh=%0d got=%0d exp=%0d", f, a, sh, lat, exp_lat);
        end
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL result f=%0d a=%h b=%h sh=%0d got=%h exp=%h (res,z,n,c,v,err)",
                     f, a, b, sh, obs(), e);
        end
        @(posedge clk); #1;
        total++;
        if (bus.out_valid !== 1'b0 || state_o !== IDLE) begin
            bad++;
            $display("FAIL consume f=%0d got out_valid=%b state=%0d exp 0/IDLE",
                     f, bus.out_valid, state_o);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
        end
        total++;
        if (obs() !== '0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=0", obs());
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
        total++;
        if (state_o !== IDLE) begin
            bad++; $display("FAIL reset_state got=%0d exp=%0d", state_o, IDLE);
        end
    endtask

    task automatic test_directed();
        run_op(4'd0, 8'd12,  8'd3,  3'd0);
        run_op(4'd1, 8'd3,   8'd12, 3'd0);
        run_op(4'd0, 8'h7F,  8'h01, 3'd0);
        run_op(4'd7, 8'h90,  8'h00, 3'd2);
        run_op(4'd8, 8'h90,  8'h00, 3'd2);
        run_op(4'd6, 8'h40,  8'h00, 3'd1);
        run_op(4'd7, 8'hA5,  8'h00, 3'd0);
        run_op(4'd6, 8'hC3,  8'h00, 3'd7);
        run_op(4'd1, 8'h80,  8'h01, 3'd0);
        run_op(4'd0, 8'hFF,  8'h01, 3'd0);
    endtask

    task automatic test_illegal();
        run_op(4'd12, 8'h5A, 8'h33, 3'd4);
        run_op(4'd0,  8'd20, 8'd22, 3'd0);
        run_op(4'd15, 8'h00, 8'hFF, 3'd0);
        run_op(4'd5,  8'h0F, 8'h00, 3'd0);
    endtask

    task automatic test_backpressure();
        logic [W+4:0] e_and, e_or;
        e_and = model(4'd2, 8'hF0, 8'h3C, 3'd0);
        e_or  = model(4'd3, 8'h0F, 8'h50, 3'd0);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.funct = 4'd2;  bus.a = 8'hF0;  bus.b = 8'h3C;  bus.shamt = '0;
        @(posedge clk); #1;
        bus.funct = 4'd3;  bus.a = 8'h0F;  bus.b = 8'h50;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (bus.out_valid !== 1'b1 || obs() !== e_and || bus.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d got valid=%b out=%h rdy=%b exp 1/%h/0",
                         i, bus.out_valid, obs(), bus.in_ready, e_and);
            end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 1'b1 || obs() !== e_or) begin
            bad++;
            $display("FAIL bp_queued_or got valid=%b out=%h exp 1/%h", bus.out_valid, obs(), e_or);
        end
        @(posedge clk); #1;
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_drain got=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]   f;
        logic [W+4:0] e;
        for (int i = 0; i < 24; i++) begin
            f = (i % 5 == 4) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 5));
            bus.in_valid = 1'b1;
            bus.funct = f;  bus.a = W'($urandom);  bus.b = W'($urandom);
            bus.shamt = SW'($urandom);
            exp_q.push_back(model(f, bus.a, bus.b, bus.shamt));
            total++;
            if (bus.in_ready !== 1'b1) begin
                bad++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, bus.in_ready);
            end
            @(posedge clk); #1;
            e = exp_q.pop_front();
            total++;
            if (bus.out_valid !== 1'b1 || obs() !== e) begin
                bad++;
                $display("FAIL b2b_result i=%0d f=%0d got valid=%b out=%h exp 1/%h",
                         i, f, bus.out_valid, obs(), e);
            end
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_drain got=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic seen_valid;
        bus.in_valid = 1'b1;
        bus.funct = 4'd7;  bus.a = 8'hB3;  bus.b = 8'h00;  bus.shamt = 3'd5;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        total++;
        if (state_o !== SHIFT) begin
            bad++; $display("FAIL mid_shift_entry got=%0d exp=%0d", state_o, SHIFT);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || state_o !== IDLE || obs() !== '0) begin
            bad++;
            $display("FAIL mid_shift_abort got valid=%b state=%0d out=%h exp 0/IDLE/0",
                     bus.out_valid, state_o, obs());
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) seen_valid = 1'b1;
        end
        total++;
        if (seen_valid !== 1'b0) begin
            bad++; $display("FAIL mid_shift_emit got=%b exp=0", seen_valid);
        end
        run_op(4'd7, 8'hB3, 8'h00, 3'd5);
        run_op(4'd0, 8'd100, 8'd27, 3'd0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            run_op(4'($urandom_range(0, 15)), W'($urandom), W'($urandom), SW'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
- Parametrised, registered successor to the 4-bit FPGA ALU.
- Operand width is WIDTH (default 32). Results and flags are registered.
- Input and output use valid/ready handshakes.
- Shifts run iteratively, one bit per cycle, so long shifts do not need a barrel shifter.
- Sits between the register-file read stage and writeback in the datapath.

Parameters:
- WIDTH, 32, operand and result width in bits (minimum 4).
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and funct are valid this cycle.
- in_ready  out  1  core can accept an operation.
- a  in  WIDTH  operand A; also the shift source.
- b  in  WIDTH  operand B.
- shamt  in  SHW  shift amount.
- funct  in  4  operation code.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  operation result.
- flag_z  out  1  result == 0.
- flag_n  out  1  result[WIDTH-1].
- flag_c  out  1  carry, no-borrow, or last bit shifted out.
- flag_v  out  1  signed overflow.
- err  out  1  funct was not a legal code.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - out_valid, result, all flags and err = 0.
  - in_ready is 1 once rst_n is high.
- Funct codes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5 (~a), SLA=6, SRA=7, SRL=8. Codes 9-15 are illegal.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - An operation is accepted on a cycle where in_valid && in_ready.
  - out_valid holds, with result and flags stable, until out_valid && out_ready.
  - Accepting a new operation in the same cycle the old result is consumed is allowed. This gives 1 op/cycle throughput for non-shift ops.
- Non-shift ops: result registered on the accept edge; out_valid=1 the following cycle (latency 1).
- ADD: {c, result} = a + b. v = (a[MSB]==b[MSB]) && (result[MSB]!=a[MSB]).
- SUB: result = a - b. c = 1 when a >= b unsigned (no borrow). v = (a[MSB]!=b[MSB]) && (result[MSB]!=a[MSB]).
- AND, OR, XOR, NOT: c = 0, v = 0.
- Illegal funct: result = 0, z = 1, err = 1, latency 1. err clears on the next accepted legal operation.
- Shifts (SLA, SRA, SRL):
  - On accept, latch a into the working register and shamt into a down-counter.
  - If shamt == 0: result = a, c = 0, latency 1, no SHIFT state.
  - Otherwise enter SHIFT. Each cycle shift one bit and decrement the counter. c captures the bit shifted out.
    - SLA: shift left, LSB filled with 0. v = 1 if the sign bit changes on any step (sticky for this op).
    - SRA: shift right, MSB replicated.
    - SRL: shift right, MSB filled with 0.
  - When the counter reaches 0, go to DONE. out_valid = 1 on the cycle after the last shift step, so total latency = shamt + 1 cycles.
  - in_ready = 0 throughout SHIFT.
- State machine:
  - IDLE -> SHIFT on accepting a shift op with shamt != 0.
  - SHIFT -> SHIFT while count > 1.
  - SHIFT -> DONE on the last step.
  - DONE -> IDLE when the result is consumed, or immediately if out_valid was never blocked.
  - DONE is the state in which out_valid is asserted after a shift.
- Flags z and n are computed from the final result for every op.
- Reset mid-shift: immediate abort to IDLE. Nothing is emitted; out_valid stays 0.
- in_valid while in_ready = 0: ignored. The upstream must hold its inputs until accepted.

Decomposition:
- Package alu_pkg holds:
  - funct localparams ADD..SRL;
  - state encoding IDLE, SHIFT, DONE;
  - shift-kind encoding.
- One sub-module, alu_shift_step: combinational single-bit shift of WIDTH bits. Inputs are data and kind; outputs are the shifted data, the bit shifted out, and a sign-change flag. It is instantiated once inside alu_seq_core.

Test Plan (WIDTH=8):
- ADD a=12, b=3, out_ready=1 -> result=15, z=0, n=0, c=0, v=0; out_valid exactly 1 cycle after accept.
- SUB a=3, b=12 -> result=0xF7, n=1, c=0, v=0. Then ADD a=0x7F, b=0x01 -> result=0x80, v=1, n=1.
- SRA a=0x90, shamt=2 -> in_ready low for 2 cycles; result=0xE4, c=0; out_valid at accept+3. SRL of the same operands -> 0x24. SLA a=0x40, shamt=1 -> 0x80, v=1.
- Backpressure: out_ready=0 for 5 cycles after an AND of a=0xF0, b=0x3C -> result held at 0x30 and in_ready=0 throughout; on out_ready=1 a queued OR is accepted in the same cycle.
- Illegal funct=12 -> result=0, z=1, err=1, latency 1. The next legal ADD clears err.
- Assert rst_n low during SRA shamt=5 at step 2 -> out_valid stays 0, state IDLE; the next op after release behaves normally.
